wb_bus_matrix: RTL and testbench

- Wishbone shared-bus interconnect that sits directly downstream of the CPU core's two Wishbone master ports: instruction fetch (m1) and data access (m0).
- Arbitrates the two masters onto one shared bus and decodes address[31:28] to one of three slaves: ROM, UART/GPIO, RAM.
- Any unmapped address is terminated by an internal default slave.
- A watchdog terminates any transfer a slave never acknowledges.

---
 rtl/wb_bus_matrix_pkg.sv | 20 ++
 rtl/wb_bus_matrix_watchdog.sv | 23 ++
 rtl/wb_bus_matrix.sv | 103 ++++++++++
 tb/tb_wb_bus_matrix.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_matrix_pkg.sv
// wb_bus_matrix_pkg: shared constants, grant/state encodings and address decode helper
package wb_bus_matrix_pkg;
    localparam int NSLV = 3;
    localparam logic [3:0] S0_TAG_DEF = 4'h0;
    localparam logic [3:0] S1_TAG_DEF = 4'h1;
    localparam logic [3:0] S2_TAG_DEF = 4'h3;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;
    // State encoding doubles as the grant output encoding
    typedef enum logic [1:0] {
        ST_IDLE = GNT_NONE,
        ST_M0   = GNT_M0,
        ST_M1   = GNT_M1
    } arb_state_e;
    function automatic logic [NSLV-1:0] decode(input logic [3:0] tag, input logic [3:0] t0,
                                               input logic [3:0] t1, input logic [3:0] t2);
        return {tag == t2, tag == t1, tag == t0};
    endfunction
endpackage

// File: rtl/wb_bus_matrix_watchdog.sv
// wb_watchdog: counts unacknowledged strobe cycles and forces an ack after TIMEOUT of them
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    input  logic clr,
    output logic forced_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        forced_o = req & (cnt_q == TMAX);
        cnt_d    = (clr | ~req | ack | forced_o) ? '0 : cnt_q + CW'(1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/wb_bus_matrix.sv
// wb_bus_matrix: two-master Wishbone shared bus with address decode, default slave and watchdog
module wb_bus_matrix
    import wb_bus_matrix_pkg::*;
#(
    parameter logic [3:0] S0_TAG  = S0_TAG_DEF,
    parameter logic [3:0] S1_TAG  = S1_TAG_DEF,
    parameter logic [3:0] S2_TAG  = S2_TAG_DEF,
    parameter int         TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      m0_addr_i,
    input  logic [31:0]      m1_addr_i,
    input  logic [31:0]      m0_data_i,
    input  logic [31:0]      m1_data_i,
    input  logic             m0_we_i,
    input  logic             m1_we_i,
    input  logic [3:0]       m0_sel_i,
    input  logic [3:0]       m1_sel_i,
    input  logic             m0_stb_i,
    input  logic             m1_stb_i,
    input  logic             m0_cyc_i,
    input  logic             m1_cyc_i,
    output logic [31:0]      m0_data_o,
    output logic [31:0]      m1_data_o,
    output logic             m0_ack_o,
    output logic             m1_ack_o,
    output logic [31:0]      s_addr_o,
    output logic [31:0]      s_data_o,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic [NSLV-1:0]  s_stb_o,
    output logic [NSLV-1:0]  s_cyc_o,
    input  logic [32*NSLV-1:0] s_data_i,
    input  logic [NSLV-1:0]  s_ack_i,
    output logic [1:0]       gnt_o,
    output logic             bus_err_o
);
    arb_state_e state_q, state_d;
    logic dflt_ack_q, dflt_ack_d, bus_err_q, bus_err_d;
    logic g0, g1, cyc, stb, slv_ack, wd_req, dflt_req, forced, dflt_ack, ack;
    logic [NSLV-1:0] hit;
    logic [31:0] rdata;

    always_comb begin
        g0       = (state_q == ST_M0);
        g1       = (state_q == ST_M1);
        s_addr_o = g0 ? m0_addr_i : (g1 ? m1_addr_i : '0);
        s_data_o = g0 ? m0_data_i : (g1 ? m1_data_i : '0);
        s_we_o   = (g0 & m0_we_i) | (g1 & m1_we_i);
        s_sel_o  = g0 ? m0_sel_i : (g1 ? m1_sel_i : '0);
        cyc      = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
        stb      = cyc & ((g0 & m0_stb_i) | (g1 & m1_stb_i));
        hit      = decode(s_addr_o[31:28], S0_TAG, S1_TAG, S2_TAG);
        s_cyc_o  = {NSLV{cyc}} & hit;
        slv_ack  = |(s_ack_i & s_cyc_o);
        wd_req   = stb & (|hit);
        dflt_req = stb & ~(|hit);
        state_d  = (state_q == ST_IDLE) ? (m0_cyc_i ? ST_M0 : (m1_cyc_i ? ST_M1 : ST_IDLE))
                                        : (cyc ? state_q : ST_IDLE);
    end

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .req      (wd_req),
        .ack      (slv_ack),
        .clr      (state_d != state_q),
        .forced_o (forced)
    );

    // Return path: forced and default-slave acks carry no data
    always_comb begin
        s_stb_o    = {NSLV{stb & ~forced}} & hit;
        dflt_ack   = dflt_ack_q & (g0 | g1);
        ack        = slv_ack | dflt_ack | forced;
        rdata      = forced     ? '0 :
                     s_cyc_o[0] ? s_data_i[31:0] :
                     s_cyc_o[1] ? s_data_i[63:32] :
                     s_cyc_o[2] ? s_data_i[95:64] : '0;
        m0_ack_o   = g0 & ack;
        m1_ack_o   = g1 & ack;
        m0_data_o  = g0 ? rdata : '0;
        m1_data_o  = g1 ? rdata : '0;
        dflt_ack_d = dflt_req & ~dflt_ack_q;
        bus_err_d  = bus_err_q | dflt_ack | forced;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dflt_ack_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dflt_ack_q <= dflt_ack_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign gnt_o     = state_q;
    assign bus_err_o = bus_err_q;
endmodule

// File: tb/tb_wb_bus_matrix.sv
// tb_wb_bus_matrix: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_wb_bus_matrix;
    localparam int TO = 8;
    logic clk = 0, rst = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdat = 0, m1_wdat = 0;
    logic m0_we = 0, m1_we = 0, m0_stb = 0, m1_stb = 0, m0_cyc = 0, m1_cyc = 0;
    logic [3:0] m0_sel = 0, m1_sel = 0;
    logic [95:0] s_data_i = 0;
    logic [2:0] s_ack_i = 0;
    logic [31:0] m0_rdat, m1_rdat, s_addr, s_wdat;
    logic m0_ack, m1_ack, s_we, bus_err;
    logic [3:0] s_sel;
    logic [2:0] s_stb, s_cyc;
    logic [1:0] gnt;
    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] a, d;
        logic we, cyc, stb;
        logic [3:0] sel;
    } mreq_t;

    int owner = 0, waited = 0;
    bit dphase = 0, err = 0;

    wb_bus_matrix #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_data_i(m0_wdat), .m1_data_i(m1_wdat),
        .m0_we_i(m0_we), .m1_we_i(m1_we), .m0_sel_i(m0_sel), .m1_sel_i(m1_sel),
        .m0_stb_i(m0_stb), .m1_stb_i(m1_stb), .m0_cyc_i(m0_cyc), .m1_cyc_i(m1_cyc),
        .m0_data_o(m0_rdat), .m1_data_o(m1_rdat), .m0_ack_o(m0_ack), .m1_ack_o(m1_ack),
        .s_addr_o(s_addr), .s_data_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt), .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slot(input logic [31:0] a);
        case (a[31:28])
            4'h0:    return 0;
            4'h1:    return 1;
            4'h3:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic mreq_t granted(input int own);
        mreq_t r;
        r = '{a: 0, d: 0, we: 0, cyc: 0, stb: 0, sel: 0};
        if (own == 1) r = '{a: m0_addr, d: m0_wdat, we: m0_we, cyc: m0_cyc, stb: m0_stb, sel: m0_sel};
        if (own == 2) r = '{a: m1_addr, d: m1_wdat, we: m1_we, cyc: m1_cyc, stb: m1_stb, sel: m1_sel};
        return r;
    endfunction

    task automatic compare_cycle();
        mreq_t g;
        int k, ks;
        bit req, mapped, forced, ack;
        logic [31:0] rd;
        g      = granted(owner);
        k      = slot(g.a);
        ks     = (k < 0) ? 0 : k;
        req    = g.cyc && g.stb;
        mapped = g.cyc && k >= 0;
        forced = req && k >= 0 && waited == TO;
        ack    = (mapped && s_ack_i[ks]) || (dphase && owner != 0) || forced;
        rd     = (mapped && !forced) ? s_data_i[ks*32 +: 32] : 32'h0;
        chk("cmp_gnt", 32'(gnt), owner);
        chk("cmp_s_addr", s_addr, g.a);
        chk("cmp_s_data", s_wdat, g.d);
        chk("cmp_s_we", 32'(s_we), 32'(g.we));
        chk("cmp_s_sel", 32'(s_sel), 32'(g.sel));
        chk("cmp_s_cyc", 32'(s_cyc), mapped ? (1 << k) : 0);
        chk("cmp_s_stb", 32'(s_stb), (req && k >= 0 && !forced) ? (1 << k) : 0);
        chk("cmp_m0_ack", 32'(m0_ack), (owner == 1) ? 32'(ack) : 0);
        chk("cmp_m1_ack", 32'(m1_ack), (owner == 2) ? 32'(ack) : 0);
        chk("cmp_m0_data", m0_rdat, (owner == 1) ? rd : 0);
        chk("cmp_m1_data", m1_rdat, (owner == 2) ? rd : 0);
        chk("cmp_bus_err", 32'(bus_err), 32'(err));
    endtask

    task automatic model_step();
        mreq_t g;
        int k, ks;
        bit req, forced, sack, dack;
        g      = granted(owner);
        k      = slot(g.a);
        ks     = (k < 0) ? 0 : k;
        req    = g.cyc && g.stb;
        forced = req && k >= 0 && waited == TO;
        sack   = g.cyc && k >= 0 && s_ack_i[ks];
        dack   = dphase && owner != 0;
        err    = err || dack || forced;
        waited = (req && k >= 0 && !sack && !forced) ? waited + 1 : 0;
        dphase = req && k < 0 && !dphase;
        if (owner == 0) owner = m0_cyc ? 1 : (m1_cyc ? 2 : 0);
        else if (!g.cyc) owner = 0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner = 0; waited = 0; dphase = 0; err = 0;
        end else model_step();
    end

    always @(negedge clk) compare_cycle();

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk); #1; endtask

    task automatic req(input int m, input logic [31:0] a, input logic [31:0] d, input logic we);
        if (m == 0) begin m0_addr = a; m0_wdat = d; m0_we = we; m0_sel = we ? 4'b0001 : 4'hF; m0_cyc = 1; m0_stb = 1; end
        else        begin m1_addr = a; m1_wdat = d; m1_we = we; m1_sel = we ? 4'b0001 : 4'hF; m1_cyc = 1; m1_stb = 1; end
    endtask

    task automatic drop(input int m);
        if (m == 0) begin m0_cyc = 0; m0_stb = 0; m0_we = 0; end
        else        begin m1_cyc = 0; m1_stb = 0; m1_we = 0; end
    endtask

    task automatic wait_gnt(input logic [1:0] g);
        int n = 0;
        while (gnt !== g && n < 20) begin tick(); n++; end
        chk("wait_gnt", 32'(gnt), 32'(g));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        s_data_i = {32'hA5A5_0001, 32'h5555_0002, 32'hCAFE_0004};
        req(0, 32'h3000_0010, 0, 0);
        req(1, 32'h0000_0004, 0, 0);
        repeat (3) tick();
        mid();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_s_stb", 32'(s_stb), 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m0_ack", 32'(m0_ack), 0);
        rst = 1; #1;
        chk("release_gnt", 32'(gnt), 0);
        tick(); tick();
        chk("sim_gnt_m0", 32'(gnt), 1);
        chk("sim_stb_ram", 32'(s_stb), 3'b100);
        s_ack_i = 3'b100; #1;
        chk("sim_m0_ack", 32'(m0_ack), 1);
        chk("sim_m0_data", m0_rdat, 32'hA5A5_0001);
        chk("sim_m1_ack", 32'(m1_ack), 0);
        tick(); s_ack_i = 0; drop(0); #1;
        chk("flush_stb", 32'(s_stb), 0);
        tick();
        chk("bubble_gnt", 32'(gnt), 0);
        tick();
        chk("m1_gnt", 32'(gnt), 2);
        chk("m1_stb_rom", 32'(s_stb), 3'b001);
        s_ack_i = 3'b001; #1;
        chk("m1_ack", 32'(m1_ack), 1);
        chk("m1_data", m1_rdat, 32'hCAFE_0004);
        tick(); s_ack_i = 0; drop(1);
        req(0, 32'h1000_0000, 32'h41, 1);
        wait_gnt(2'b01);
        chk("uart_we", 32'(s_we), 1);
        chk("uart_sel", 32'(s_sel), 4'b0001);
        chk("uart_stb", 32'(s_stb), 3'b010);
        chk("uart_wdat", s_wdat, 32'h41);
        s_ack_i = 3'b010; #1;
        chk("uart_ack", 32'(m0_ack), 1);
        tick(); s_ack_i = 0; drop(0); #1;
        chk("uart_err", 32'(bus_err), 0);
        req(1, 32'h7000_0000, 0, 0);
        wait_gnt(2'b10);
        chk("unm_ack1", 32'(m1_ack), 0);
        chk("unm_cyc", 32'(s_cyc), 0);
        tick();
        chk("unm_ack2", 32'(m1_ack), 1);
        chk("unm_data", m1_rdat, 0);
        chk("unm_err_pre", 32'(bus_err), 0);
        tick();
        chk("unm_err_post", 32'(bus_err), 1);
        chk("unm_ack3", 32'(m1_ack), 0);
        tick();
        chk("unm_ack4", 32'(m1_ack), 1);
        drop(1);
        tick(); mid();
        rst = 0; #1;
        chk("pulse_err_clr", 32'(bus_err), 0);
        rst = 1;
        req(0, 32'h3000_0000, 0, 0);
        wait_gnt(2'b01);
        for (int i = 1; i <= TO; i++) begin
            chk("to_wait_ack", 32'(m0_ack), 0);
            chk("to_wait_stb", 32'(s_stb), 3'b100);
            tick();
        end
        chk("to_ack", 32'(m0_ack), 1);
        chk("to_stb_mask", 32'(s_stb), 0);
        chk("to_data", m0_rdat, 0);
        tick();
        chk("to_err", 32'(bus_err), 1);
        chk("to_restart_stb", 32'(s_stb), 3'b100);
        drop(0);
        tick();
        req(0, 32'h3000_0020, 0, 0);
        wait_gnt(2'b01);
        tick(); tick(); tick();
        drop(0); #1;
        chk("abort_stb", 32'(s_stb), 0);
        chk("abort_cyc", 32'(s_cyc), 0);
        tick();
        chk("abort_gnt", 32'(gnt), 0);
        s_ack_i = 3'b100; #1;
        chk("late_ack", 32'(m0_ack), 0);
        tick(); s_ack_i = 0;
        req(1, 32'h0000_0008, 0, 0);
        wait_gnt(2'b10);
        chk("pre_rst_err", 32'(bus_err), 1);
        mid();
        rst = 0; #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_err", 32'(bus_err), 0);
        chk("mid_rst_stb", 32'(s_stb), 0);
        tick();
        rst = 1; drop(1);
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
